// File: rtl/dice_pkg.sv
// dice_pkg
// Shared types and helpers for the multi-die roller.
//   roll_state_t : roller phase (IDLE, ROLL, SETTLE, DONE)
//   die_width    : bits needed to hold 0..faces for one die
//   sum_width    : bits needed to hold the sum of all dice
//   face_lsb     : LSB position of a die's field inside the packed faces bus
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROLL   = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } roll_state_t;

  // Eight bits covers the full settle range of 0..255 cycles.
  localparam int SETTLE_CNT_W = 8;

  function automatic int die_width(input int faces);
    return $clog2(faces + 1);
  endfunction

  function automatic int sum_width(input int dice, input int faces);
    return $clog2(dice * faces + 1);
  endfunction

  function automatic int face_lsb(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/die_counter.sv
// die_counter
// One modulo-FACES die. Counts 1..FACES and wraps back to 1; 0 only after reset.
// Ports:
//   clk   : clock, posedge
//   rst   : synchronous active-high reset, clears the die to 0
//   load1 : force the die to 1 (start of a roll)
//   step  : advance the die by one face this cycle
//   value : current face, 0 = no roll yet
//   wrap  : high when this step takes the die from FACES back to 1
module die_counter
  import dice_pkg::*;
#(
  parameter int FACES = 6,
  parameter int W     = die_width(FACES)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load1,
  input  logic         step,
  output logic [W-1:0] value,
  output logic         wrap
);

  // Wrap is combinational so the next die in the chain steps in the same
  // cycle this one rolls over, giving odometer behaviour.
  assign wrap = step && (value == W'(FACES));

  // Face register: load wins over step so a fresh roll always starts at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (load1) begin
      value <= W'(1);
    end else if (step) begin
      value <= wrap ? W'(1) : value + W'(1);
    end
  end

endmodule

// File: rtl/dice_roller.sv
// dice_roller
// Multi-die roller: dice spin as a chained odometer while btn is held, keep
// spinning SETTLE_CYCLES cycles after release, then freeze and pulse valid.
// Ports:
//   clk    : clock, posedge
//   rst    : synchronous active-high reset, overrides enable
//   enable : when low, state, faces and settle counter hold; valid is 0
//   btn    : debounced roll request, level sensitive
//   faces  : die i in bits [i*W +: W]; 0 = no roll yet
//   busy   : high while rolling or settling
//   choose : high while the result is held
//   valid  : one-cycle pulse on entry to the held result
//   sum    : sum of all dice (only when DICE_SUM_EN is defined)
// Optional feature macro: DICE_SUM_EN adds the sum port and its adder.
module dice_roller
  import dice_pkg::*;
#(
  parameter int FACES         = 6,
  parameter int DICE          = 2,
  parameter int SETTLE_CYCLES = 4,
  localparam int W            = die_width(FACES)
`ifdef DICE_SUM_EN
  ,
  localparam int SW           = sum_width(DICE, FACES)
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                btn,
  output logic [DICE*W-1:0]   faces,
  output logic                busy,
  output logic                choose,
  output logic                valid
`ifdef DICE_SUM_EN
  ,
  output logic [SW-1:0]       sum
`endif
);

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST =
    SETTLE_CNT_W'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);

  roll_state_t             state;
  roll_state_t             next_state;
  logic [SETTLE_CNT_W-1:0] settle_cnt;
  logic                    advance;
  logic                    load_all;
  logic                    cnt_clear;
  logic                    done_pulse;
  logic [DICE-1:0]         wrap;
  logic                    unused_top_wrap;

  // Die bank: die 0 steps on every advance, each later die steps only when
  // its lower neighbour wraps.
  for (genvar i = 0; i < DICE; i++) begin : g_die
    logic step_i;
    if (i == 0) begin : g_first
      assign step_i = advance;
    end else begin : g_chain
      assign step_i = wrap[i-1];
    end
    die_counter #(
      .FACES(FACES),
      .W    (W)
    ) u_die (
      .clk  (clk),
      .rst  (rst),
      .load1(load_all),
      .step (step_i),
      .value(faces[face_lsb(i, W) +: W]),
      .wrap (wrap[i])
    );
  end

  // The top die's carry has nowhere to go.
  assign unused_top_wrap = wrap[DICE-1];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (enable) begin
      state <= next_state;
    end
  end

  // Next-state and datapath strobes. Everything is gated by enable so a
  // frozen roller neither moves nor advances its dice. In SETTLE a new
  // press takes priority over finishing, even on the last settle cycle.
  // Leaving DONE does not advance; the dice resume on the following ROLL
  // cycles from where they stopped.
  always_comb begin
    next_state = state;
    advance    = 1'b0;
    load_all   = 1'b0;
    cnt_clear  = 1'b0;
    if (enable) begin
      unique case (state)
        IDLE: begin
          if (btn) begin
            next_state = ROLL;
            load_all   = 1'b1;
          end
        end
        ROLL: begin
          if (btn) begin
            advance = 1'b1;
          end else begin
            cnt_clear  = 1'b1;
            next_state = (SETTLE_CYCLES == 0) ? DONE : SETTLE;
          end
        end
        SETTLE: begin
          advance = 1'b1;
          if (btn) begin
            next_state = ROLL;
            cnt_clear  = 1'b1;
          end else if (settle_cnt == SETTLE_LAST) begin
            next_state = DONE;
          end
        end
        DONE: begin
          if (btn) begin
            next_state = ROLL;
          end
        end
      endcase
    end
  end

  // Settle counter: counts advances made in SETTLE since the last release.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= '0;
    end else if (enable) begin
      if (cnt_clear) begin
        settle_cnt <= '0;
      end else if (state == SETTLE) begin
        settle_cnt <= settle_cnt + SETTLE_CNT_W'(1);
      end
    end
  end

  // Entry-to-DONE marker. A frozen cycle clears it, so a pulse masked by
  // enable low is dropped rather than replayed later.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= enable && (next_state == DONE) && (state != DONE);
    end
  end

  // Output decode from registered state only; btn never reaches an output.
  always_comb begin
    busy   = (state == ROLL) || (state == SETTLE);
    choose = (state == DONE);
    valid  = done_pulse && enable;
  end

`ifdef DICE_SUM_EN
  // Sum of the registered faces, zero extended; 0 in IDLE since all faces are 0.
  always_comb begin
    sum = '0;
    for (int i = 0; i < DICE; i++) begin
      sum = sum + SW'(faces[face_lsb(i, W) +: W]);
    end
  end
`endif

endmodule

// File: tb/tb_dice_roller.sv
// tb_dice_roller
// Bench for dice_roller: two instances (settle 4 and settle 0) share one
// stimulus stream and are compared every half cycle against a model that
// treats the dice bank as one integer counting modulo FACES**DICE.
// Honours DICE_SUM_EN when defined.
module tb_dice_roller;

  localparam int FA = 6;
  localparam int DA = 2;
  localparam int SA = 4;
  localparam int WA = $clog2(FA + 1);
  localparam int FB = 6;
  localparam int DB = 3;
  localparam int SB = 0;
  localparam int WB = $clog2(FB + 1);

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic btn;

  logic [DA*WA-1:0] faces_a;
  logic             busy_a, choose_a, valid_a;
  logic [DB*WB-1:0] faces_b;
  logic             busy_b, choose_b, valid_b;
`ifdef DICE_SUM_EN
  logic [$clog2(DA*FA+1)-1:0] sum_a;
  logic [$clog2(DB*FB+1)-1:0] sum_b;
`endif

  always #5 clk = ~clk;

  dice_roller #(.FACES(FA), .DICE(DA), .SETTLE_CYCLES(SA)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .btn(btn),
    .faces(faces_a), .busy(busy_a), .choose(choose_a), .valid(valid_a)
`ifdef DICE_SUM_EN
    , .sum(sum_a)
`endif
  );

  dice_roller #(.FACES(FB), .DICE(DB), .SETTLE_CYCLES(SB)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .btn(btn),
    .faces(faces_b), .busy(busy_b), .choose(choose_b), .valid(valid_b)
`ifdef DICE_SUM_EN
    , .sum(sum_b)
`endif
  );

  // Model: the dice bank is the integer n; die i shows digit i of n in base
  // FACES, plus one. left counts settle advances still to come.
  typedef struct {
    int faces;
    int dice;
    int settle;
    bit started;
    bit rolling;
    int left;
    bit done;
    bit pulse;
    int n;
  } model_t;

  model_t ma, mb;
  int checks   = 0;
  int failures = 0;

  function automatic model_t modelReset(input int f, input int d, input int s);
    model_t m;
    m.faces = f; m.dice = d; m.settle = s;
    m.started = 0; m.rolling = 0; m.left = 0; m.done = 0; m.pulse = 0; m.n = 0;
    return m;
  endfunction

  function automatic model_t modelStep(input model_t mi, input bit b, input bit e, input bit r);
    model_t m;
    int total;
    m = mi;
    if (r) return modelReset(m.faces, m.dice, m.settle);
    m.pulse = 0;
    if (!e) return m;
    total = m.faces ** m.dice;
    if (!m.started) begin
      if (b) begin m.started = 1; m.rolling = 1; m.n = 0; end
    end else if (m.rolling) begin
      if (b) m.n = (m.n + 1) % total;
      else begin
        m.rolling = 0;
        if (m.settle == 0) begin m.done = 1; m.pulse = 1; end
        else m.left = m.settle;
      end
    end else if (m.left > 0) begin
      m.n = (m.n + 1) % total;
      if (b) begin m.rolling = 1; m.left = 0; end
      else begin
        m.left--;
        if (m.left == 0) begin m.done = 1; m.pulse = 1; end
      end
    end else if (m.done) begin
      if (b) begin m.done = 0; m.rolling = 1; end
    end
    return m;
  endfunction

  function automatic int digit(input model_t m, input int i);
    if (!m.started) return 0;
    return (m.n / (m.faces ** i)) % m.faces + 1;
  endfunction

  task automatic checkVec(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic checkOutput();
    logic [31:0] fa, fb;
    int          sa, sb;
    fa = '0; fb = '0; sa = 0; sb = 0;
    for (int i = 0; i < DA; i++) begin
      fa[i*WA +: WA] = WA'(digit(ma, i));
      sa += digit(ma, i);
    end
    for (int i = 0; i < DB; i++) begin
      fb[i*WB +: WB] = WB'(digit(mb, i));
      sb += digit(mb, i);
    end
    checkVec("a.faces",  32'(faces_a),  fa);
    checkVec("a.busy",   32'(busy_a),   32'(ma.rolling || ma.left > 0));
    checkVec("a.choose", 32'(choose_a), 32'(ma.done));
    checkVec("a.valid",  32'(valid_a),  32'(ma.pulse && enable));
    checkVec("b.faces",  32'(faces_b),  fb);
    checkVec("b.busy",   32'(busy_b),   32'(mb.rolling || mb.left > 0));
    checkVec("b.choose", 32'(choose_b), 32'(mb.done));
    checkVec("b.valid",  32'(valid_b),  32'(mb.pulse && enable));
`ifdef DICE_SUM_EN
    checkVec("a.sum", 32'(sum_a), 32'(sa));
    checkVec("b.sum", 32'(sum_b), 32'(sb));
`endif
  endtask

  // One clock of stimulus: drive at negedge, check, clock, update model, check.
  task automatic applyStimulus(input bit b, input bit e, input bit r);
    @(negedge clk);
    btn = b; enable = e; rst = r;
    #1 checkOutput();
    @(posedge clk);
    ma = modelStep(ma, b, e, r);
    mb = modelStep(mb, b, e, r);
    #1 checkOutput();
  endtask

  initial begin
    int          die0_seq [7] = '{1, 2, 3, 4, 5, 6, 1};
    int          die1_seq [7] = '{1, 1, 1, 1, 1, 1, 2};
    logic [31:0] held;
    bit          rb;

    btn = 0; enable = 1; rst = 1;
    repeat (2) @(posedge clk);
    ma = modelReset(FA, DA, SA);
    mb = modelReset(FB, DB, SB);
    #1 checkOutput();
    checkVec("reset.faces", 32'(faces_a), 0);

    // Odometer: load plus six advances.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1, 1, 0);
      checkVec("odo.die0", 32'(faces_a[WA-1:0]), die0_seq[i]);
      checkVec("odo.die1", 32'(faces_a[2*WA-1:WA]), die1_seq[i]);
    end

    // Reset mid-roll after ten held cycles.
    repeat (3) applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 1);
    checkVec("rst.faces", 32'(faces_a), 0);
    checkVec("rst.busy", 32'(busy_a), 0);
    checkVec("rst.choose", 32'(choose_a), 0);
    checkVec("rst.valid", 32'(valid_a), 0);

    // Settle length: release with die0 = 3.
    applyStimulus(0, 1, 0);
    repeat (3) applyStimulus(1, 1, 0);
    applyStimulus(0, 1, 0);
    checkVec("rel.die0", 32'(faces_a[WA-1:0]), 3);
    checkVec("zero.valid", 32'(valid_b), 1);
    checkVec("zero.die0", 32'(faces_b[WB-1:0]), 3);
    repeat (4) applyStimulus(0, 1, 0);
    checkVec("settle.die0", 32'(faces_a[WA-1:0]), 1);
    checkVec("settle.valid", 32'(valid_a), 1);
    applyStimulus(0, 1, 0);
    checkVec("settle.pulse1", 32'(valid_a), 0);
    checkVec("settle.choose", 32'(choose_a), 1);

    // Re-press at settle count 2, then a full settle.
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 0);
    repeat (3) applyStimulus(0, 1, 0);
    applyStimulus(1, 1, 0);
    checkVec("repress.busy", 32'(busy_a), 1);
    applyStimulus(0, 1, 0);
    repeat (3) applyStimulus(0, 1, 0);
    checkVec("repress.nopulse", 32'(valid_a), 0);
    applyStimulus(0, 1, 0);
    checkVec("repress.valid", 32'(valid_a), 1);

    // Freeze in ROLL.
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 0);
    held = 32'(faces_a);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 0);
      checkVec("freeze.faces", 32'(faces_a), held);
    end

    // Valid cycle masked by enable low is not replayed.
    applyStimulus(0, 1, 0);
    repeat (4) applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);
    checkVec("mask.valid", 32'(valid_a), 0);
    applyStimulus(0, 1, 0);
    checkVec("mask.replay", 32'(valid_a), 0);
    checkVec("mask.choose", 32'(choose_a), 1);

    // Random phase with a sticky button level.
    rb = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 20) rb = ~rb;
      applyStimulus(rb, $urandom_range(0, 99) < 85, $urandom_range(0, 299) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dice_roller.md
# dice_roller

Parametrised multi-die roller for the game datapath: while the player holds the button, a bank of `DICE` modulo-`FACES` counters spins as a chained odometer. After release, the counters keep spinning for a fixed settle time, then freeze and present a result with a one-cycle `valid` pulse. It sits between the debounced button input and the score/display logic, and supersedes the single fixed six-sided roller.

## Interface
- `FACES`, default 6: faces per die; legal range 2..15.
- `DICE`, default 2: number of dice; legal range 1..4.
- `SETTLE_CYCLES`, default 4: advance cycles after release; legal range 0..255.
- Derived `W = $clog2(FACES+1)`: bits per die.
- Derived `SW = $clog2(DICE*FACES+1)`: sum width.

Ports:
- `clk` input, 1 bit: single clock; all logic on posedge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `enable` input, 1 bit: when low, all state and outputs freeze.
- `btn` input, 1 bit: roll request, level-sensitive, already debounced.
- `faces` output, `DICE*W` bits: die *i* in bits `[i*W +: W]`; 0 means "no roll yet", otherwise 1..`FACES`.
- `busy` output, 1 bit: high in ROLL and SETTLE.
- `choose` output, 1 bit: high in DONE; the result is stable.
- `valid` output, 1 bit: one-cycle pulse on entry to DONE.
- `sum` output, `SW` bits: sum of all dice; present only with `DICE_SUM_EN`.

## Operation
- **States:** IDLE, ROLL, SETTLE, DONE.
- **Freeze rule:** every transition and advance below requires `enable`=1. With `enable`=0, state, faces and the settle counter hold, and `valid` is 0.
- **IDLE:** all faces are 0.
  - `btn`=1 → ROLL, and all faces load 1.
- **ROLL:**
  - `btn`=1: the dice advance.
  - `btn`=0: no advance. Go to SETTLE with the settle counter cleared, or go straight to DONE if `SETTLE_CYCLES`=0.
- **Advance (odometer):**
  - Die 0 steps +1 every advance.
  - Die *i*>0 steps +1 only in a cycle where die *i*−1 wraps.
  - Wrap means `FACES` → 1. The value 0 never appears after IDLE.
- **SETTLE:** the dice advance each cycle and the counter increments.
  - Counter reaches `SETTLE_CYCLES`−1 → DONE.
  - `btn`=1 → back to ROLL with the counter cleared. The dice still advance in that cycle.
- **DONE:** faces hold and `choose`=1.
  - `btn`=1 → ROLL, with the dice advancing from their current values (no reload to 1).
- **Reset:** `rst` overrides `enable` from any state, including mid-roll. Next state is IDLE, and faces, `busy`, `choose`, `valid` and `sum` are all 0.

## Timing
- All outputs are registered or decoded from registered state, with no combinational path from `btn` to outputs.
- IDLE→ROLL: the edge with `btn`=1 loads faces=1; `busy`=1 from the next cycle.
- Release: the first edge sampling `btn`=0 in ROLL performs no advance. Exactly `SETTLE_CYCLES` further advances follow.
- `valid` is high in the cycle immediately after the final settle advance, for one cycle only. `choose` rises in that same cycle.
- With `SETTLE_CYCLES`=0, `valid` and `choose` rise in the cycle after the release edge.
- A DONE→ROLL edge drops `choose` in the following cycle.
- `enable` low during the `valid` cycle: the pulse is suppressed and not replayed. `choose` still reflects DONE.

## Configuration
- Macro: `DICE_SUM_EN`.
- **Defined:**
  - The `sum` port exists.
  - It is the combinational sum of the registered faces, zero-extended to `SW` bits.
  - It is 0 in IDLE and valid in the same cycle as `faces`.
- **Undefined:** the `sum` port and adder are removed; all other behaviour is identical.

## Structure
- Package `dice_pkg` holds:
  - the state enum `roll_state_t` (IDLE, ROLL, SETTLE, DONE);
  - the width helper functions for `W` and `SW`;
  - the face-field slice helper.
- Sub-module `die_counter`:
  - one modulo-`FACES` counter with `load1` and `step` inputs and a `wrap` output;
  - instantiated `DICE` times in a generate loop, with `wrap` chained into the next die's `step`.
- Top level holds the FSM, the settle counter and the optional sum.

## Test plan
- **Reset mid-roll:** `FACES`=6, `DICE`=2. Hold `btn` 10 cycles, then `rst`=1 for one cycle → next cycle faces=0, `busy`=0, `choose`=0, `valid`=0.
- **Odometer wrap:** `FACES`=6, `DICE`=2. From IDLE, hold `btn` for load + 6 advance cycles → die0 shows 1,2,3,4,5,6,1 and die1 steps 1→2 exactly when die0 goes 6→1.
- **Settle length:** `SETTLE_CYCLES`=4. Release with die0=3 → die0 ends at 1 (3+4 modulo 6, wrapping to 1), then `valid` pulses once and `choose` stays high.
- **Zero settle:** `SETTLE_CYCLES`=0. Release → `valid` in the next cycle, faces unchanged from the release edge.
- **Re-press during SETTLE:** `btn` high again at settle count 2 → state returns to ROLL, no `valid` pulse; after a later release, 4 full settle advances occur.
- **Freeze and sum:** hold `enable`=0 for 5 cycles in ROLL → faces constant. With `DICE_SUM_EN` and `DICE`=3, `FACES`=6, faces 6,6,6 → `sum`=18.
